// File: rtl/mon_arb_pkg.sv
// Shared encodings for the monitor/CPU data-memory arbiter: FSM states,
// owner codes and the default read response for aborted reads.
package mon_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_MON  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_t;

    localparam logic [31:0] DEF_RRESP = 32'hDEAD_BEEF;

endpackage

// File: rtl/mon_arb_timer.sv
// Busy-cycle watchdog for the arbiter: counts BUSY cycles since the last grant
// and flags the final allowed cycle (2^TO_W-1 BUSY cycles in total).
module mon_arb_timer #(
    parameter int TO_W = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic busy,
    output logic expired
);

    localparam logic [TO_W-1:0] LAST = {{(TO_W-1){1'b1}}, 1'b0};

    logic [TO_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (busy) begin
            count <= count + 1'b1;
        end
    end

    // Asserted during the last BUSY cycle so the abort lands exactly on the limit.
    assign expired = busy && (count == LAST);

endmodule

// File: rtl/mon_mem_arb.sv
// Round-robin arbiter placing UART-monitor and CPU load/store requests onto the
// single data-memory port. Optional watchdog abort enabled by ARB_TIMEOUT_EN.
import mon_arb_pkg::*;

module mon_mem_arb #(
    parameter int          TO_W  = 10,
    parameter logic [31:0] RRESP = DEF_RRESP
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m_rd_req,
    input  logic        m_rd_w,
    input  logic [31:0] m_rd_adr,
    output logic        m_rd_valid,
    output logic [31:0] m_rd_data,
    input  logic        m_wr_req,
    input  logic        m_wr_w,
    input  logic [31:0] m_wr_adr,
    input  logic [31:0] m_wr_data,
    output logic        m_wr_finish,

    input  logic        c_rd_req,
    input  logic        c_rd_w,
    input  logic [31:0] c_rd_adr,
    output logic        c_rd_valid,
    output logic [31:0] c_rd_data,
    input  logic        c_wr_req,
    input  logic        c_wr_w,
    input  logic [31:0] c_wr_adr,
    input  logic [31:0] c_wr_data,
    output logic        c_wr_finish,

    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_w,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,

    output logic [1:0]  owner,
    output logic        arb_timeout
);

    arb_state_t  state;
    owner_t      owner_q;
    logic        last_cpu;
    logic        cur_cpu;

    logic        m_pend, c_pend, grant_cpu, grant;
    logic        sel_we, sel_w;
    logic [31:0] sel_adr, sel_wdata;
    logic [31:0] rd_result;
    logic        timeout_hit;

    assign m_pend    = m_rd_req | m_wr_req;
    assign c_pend    = c_rd_req | c_wr_req;
    // Under contention the requester that did not win last time goes first.
    assign grant_cpu = c_pend && (!m_pend || !last_cpu);
    assign grant     = (state == ST_IDLE) && (m_pend || c_pend);

    assign sel_we    = grant_cpu ? c_wr_req : m_wr_req;
    assign sel_w     = grant_cpu ? (c_wr_req ? c_wr_w   : c_rd_w)
                                 : (m_wr_req ? m_wr_w   : m_rd_w);
    assign sel_adr   = grant_cpu ? (c_wr_req ? c_wr_adr : c_rd_adr)
                                 : (m_wr_req ? m_wr_adr : m_rd_adr);
    assign sel_wdata = grant_cpu ? c_wr_data : m_wr_data;

    assign rd_result = mem_ack ? mem_rdata : RRESP;
    assign owner     = owner_q;

`ifdef ARB_TIMEOUT_EN
    mon_arb_timer #(.TO_W(TO_W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (grant),
        .busy    (state == ST_BUSY),
        .expired (timeout_hit)
    );
`else
    logic [TO_W-1:0] unused_to_w;
    assign unused_to_w = '0;
    assign timeout_hit = 1'b0;
`endif

    // Single-transaction sequencer: grant in IDLE, wait for ack in BUSY,
    // pulse the winner's done strobe during the one DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            owner_q     <= OWN_NONE;
            last_cpu    <= 1'b1;
            cur_cpu     <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_w       <= 1'b0;
            mem_adr     <= '0;
            mem_wdata   <= '0;
            m_rd_valid  <= 1'b0;
            m_wr_finish <= 1'b0;
            c_rd_valid  <= 1'b0;
            c_wr_finish <= 1'b0;
            m_rd_data   <= '0;
            c_rd_data   <= '0;
            arb_timeout <= 1'b0;
        end else begin
            m_rd_valid  <= 1'b0;
            m_wr_finish <= 1'b0;
            c_rd_valid  <= 1'b0;
            c_wr_finish <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        mem_req   <= 1'b1;
                        mem_we    <= sel_we;
                        mem_w     <= sel_w;
                        mem_adr   <= sel_adr;
                        mem_wdata <= sel_wdata;
                        cur_cpu   <= grant_cpu;
                        owner_q   <= grant_cpu ? OWN_CPU : OWN_MON;
                        state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (mem_ack || timeout_hit) begin
                        mem_req  <= 1'b0;
                        owner_q  <= OWN_NONE;
                        last_cpu <= cur_cpu;
                        state    <= ST_DONE;
                        if (!mem_ack) begin
                            arb_timeout <= 1'b1;
                        end
                        if (mem_we) begin
                            if (cur_cpu) c_wr_finish <= 1'b1;
                            else         m_wr_finish <= 1'b1;
                        end else if (cur_cpu) begin
                            c_rd_valid <= 1'b1;
                            c_rd_data  <= rd_result;
                        end else begin
                            m_rd_valid <= 1'b1;
                            m_rd_data  <= rd_result;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mon_mem_arb.sv
// Scoreboard bench for mon_mem_arb: a table of single transactions followed by
// contention, reset-abort and (with ARB_TIMEOUT_EN) watchdog sequences.
module tb_mon_mem_arb;

`ifdef ARB_TIMEOUT_EN
    localparam int TB_TO_W = 4;
`else
    localparam int TB_TO_W = 10;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        m_rd_req, m_rd_w, m_wr_req, m_wr_w;
    logic [31:0] m_rd_adr, m_wr_adr, m_wr_data;
    logic        c_rd_req, c_rd_w, c_wr_req, c_wr_w;
    logic [31:0] c_rd_adr, c_wr_adr, c_wr_data;
    logic        m_rd_valid, m_wr_finish, c_rd_valid, c_wr_finish;
    logic [31:0] m_rd_data, c_rd_data;
    logic        mem_req, mem_we, mem_w, mem_ack;
    logic [31:0] mem_adr, mem_wdata, mem_rdata;
    logic [1:0]  owner;
    logic        arb_timeout;

    mon_mem_arb #(.TO_W(TB_TO_W)) dut (
        .clk(clk), .rst(rst),
        .m_rd_req(m_rd_req), .m_rd_w(m_rd_w), .m_rd_adr(m_rd_adr),
        .m_rd_valid(m_rd_valid), .m_rd_data(m_rd_data),
        .m_wr_req(m_wr_req), .m_wr_w(m_wr_w), .m_wr_adr(m_wr_adr),
        .m_wr_data(m_wr_data), .m_wr_finish(m_wr_finish),
        .c_rd_req(c_rd_req), .c_rd_w(c_rd_w), .c_rd_adr(c_rd_adr),
        .c_rd_valid(c_rd_valid), .c_rd_data(c_rd_data),
        .c_wr_req(c_wr_req), .c_wr_w(c_wr_w), .c_wr_adr(c_wr_adr),
        .c_wr_data(c_wr_data), .c_wr_finish(c_wr_finish),
        .mem_req(mem_req), .mem_we(mem_we), .mem_w(mem_w), .mem_adr(mem_adr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .owner(owner), .arb_timeout(arb_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cpu;
        logic        we;
        logic        w;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_delay;
    } vec_t;

    vec_t exp_q[$];
    vec_t cur;
    vec_t vecs[8];
    bit   have_cur = 1'b0;
    bit   stray_ack = 1'b0;
    logic prev_req = 1'b0;
    int   ack_delay = 1;
    int   busy_cnt = 0;
    int   last_busy_len = 0;
    int   done_count = 0;
    int   vectors = 0;
    int   miscompares = 0;

    function automatic vec_t mk(input logic cpu, input logic we, input logic w,
                                input logic [31:0] adr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int d);
        vec_t v;
        v.cpu = cpu; v.we = we; v.w = w; v.adr = adr;
        v.wdata = wdata; v.rdata = rdata; v.ack_delay = d;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic driveReq(input vec_t v, input logic level);
        if (v.cpu) begin
            if (v.we) begin
                c_wr_req = level; c_wr_w = v.w; c_wr_adr = v.adr; c_wr_data = v.wdata;
            end else begin
                c_rd_req = level; c_rd_w = v.w; c_rd_adr = v.adr;
            end
        end else begin
            if (v.we) begin
                m_wr_req = level; m_wr_w = v.w; m_wr_adr = v.adr; m_wr_data = v.wdata;
            end else begin
                m_rd_req = level; m_rd_w = v.w; m_rd_adr = v.adr;
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_q.push_back(v);
        ack_delay = v.ack_delay;
        driveReq(v, 1'b1);
    endtask

    task automatic waitDone(input int target, input string name);
        int n = 0;
        while (done_count < target && n < 200) begin
            tick();
            n++;
        end
        checkOutput(name, done_count, target);
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Memory model plus output monitor, both evaluated mid-cycle.
    always @(negedge clk) begin
        logic [3:0] exp_pulse;
        if (mem_req && !prev_req) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_grant", 32'd1, 32'd0);
            end else begin
                cur = exp_q.pop_front();
                have_cur = 1'b1;
                checkOutput("grant_we", mem_we, cur.we);
                checkOutput("grant_w", mem_w, cur.w);
                checkOutput("grant_adr", mem_adr, cur.adr);
                if (cur.we) checkOutput("grant_wdata", mem_wdata, cur.wdata);
                checkOutput("grant_owner", owner, cur.cpu ? 32'd2 : 32'd1);
            end
        end else if (mem_req && have_cur) begin
            checkOutput("busy_adr_stable", mem_adr, cur.adr);
            checkOutput("busy_we_stable", mem_we, cur.we);
        end
        if (!mem_req && prev_req) last_busy_len = busy_cnt;
        if (mem_req) busy_cnt++;
        else         busy_cnt = 0;
        if (mem_req && ack_delay != 0 && busy_cnt == ack_delay) begin
            mem_ack = 1'b1;
            mem_rdata = cur.rdata;
        end else begin
            mem_ack = stray_ack;
            mem_rdata = 32'h5A5A_5A5A;
        end
        prev_req = mem_req;

        if (m_rd_valid | m_wr_finish | c_rd_valid | c_wr_finish) begin
            if (!have_cur) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_pulse = cur.cpu ? (cur.we ? 4'b0001 : 4'b0010)
                                    : (cur.we ? 4'b0100 : 4'b1000);
                checkOutput("done_pulses", {m_rd_valid, m_wr_finish, c_rd_valid, c_wr_finish}, exp_pulse);
                if (!cur.we) checkOutput("rd_data", cur.cpu ? c_rd_data : m_rd_data, cur.rdata);
                checkOutput("done_owner", owner, 32'd0);
                have_cur = 1'b0;
                done_count++;
            end
        end
    end

    initial begin
        int base;
        vec_t a, b;

        vecs[0] = mk(0, 0, 1, 32'h0000_1000, 32'h0,          32'h1234_5678, 2);
        vecs[1] = mk(0, 1, 0, 32'h0000_2003, 32'h0000_00A5, 32'h0,          1);
        vecs[2] = mk(1, 0, 0, 32'h0000_3001, 32'h0,          32'h0000_00C3, 1);
        vecs[3] = mk(1, 1, 1, 32'h0000_4000, 32'hCAFE_F00D, 32'h0,          4);
        vecs[4] = mk(0, 0, 1, 32'hFFFF_FFFC, 32'h0,          32'hFFFF_FFFF, 1);
        vecs[5] = mk(1, 0, 1, 32'h0000_0000, 32'h0,          32'h0000_0000, 3);
        vecs[6] = mk(0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,          2);
        vecs[7] = mk(1, 0, 1, 32'h0000_5000, 32'h0,          32'h89AB_CDEF, 1);

        rst = 1'b1;
        {m_rd_req, m_rd_w, m_wr_req, m_wr_w, c_rd_req, c_rd_w, c_wr_req, c_wr_w} = '0;
        {m_rd_adr, m_wr_adr, m_wr_data, c_rd_adr, c_wr_adr, c_wr_data} = '0;
        repeat (3) tick();
        checkOutput("reset_mem_req", mem_req, 0);
        checkOutput("reset_owner", owner, 0);
        checkOutput("reset_m_rd_data", m_rd_data, 0);
        checkOutput("reset_c_rd_data", c_rd_data, 0);
        checkOutput("reset_pulses", {m_rd_valid, m_wr_finish, c_rd_valid, c_wr_finish}, 0);
        checkOutput("reset_timeout", arb_timeout, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            base = done_count;
            applyStimulus(vecs[i]);
            tick();
            checkOutput("grant_latency", mem_req, 1);
            waitDone(base + 1, "table_done");
            checkOutput("busy_len", last_busy_len, vecs[i].ack_delay);
            driveReq(vecs[i], 1'b0);
            tick();
        end
        repeat (3) tick();
        checkOutput("m_rd_data_held", m_rd_data, 32'hFFFF_FFFF);
        checkOutput("c_rd_data_held", c_rd_data, 32'h89AB_CDEF);

        // Simultaneous requests straight after reset: monitor goes first.
        pulseReset();
        a = mk(0, 1, 1, 32'h0000_7000, 32'h1111_2222, 32'h0, 1);
        b = mk(1, 0, 1, 32'h0000_7100, 32'h0,          32'h3333_4444, 1);
        base = done_count;
        applyStimulus(a);
        applyStimulus(b);
        waitDone(base + 1, "contend_first");
        driveReq(a, 1'b0);
        waitDone(base + 2, "contend_second");
        driveReq(b, 1'b0);
        tick();

        // Both held continuously: grants alternate M, C, M, C.
        base = done_count;
        exp_q.push_back(a); exp_q.push_back(b);
        exp_q.push_back(a); exp_q.push_back(b);
        driveReq(a, 1'b1);
        driveReq(b, 1'b1);
        waitDone(base + 4, "alternate_done");
        driveReq(a, 1'b0);
        driveReq(b, 1'b0);
        repeat (6) tick();
        checkOutput("alternate_count", done_count, base + 4);

        // Write beats read within one requester.
        a = mk(1, 1, 0, 32'h0000_9001, 32'h0000_0077, 32'h0, 1);
        b = mk(1, 0, 1, 32'h0000_9004, 32'h0,          32'hBEEF_0001, 2);
        base = done_count;
        applyStimulus(a);
        applyStimulus(b);
        waitDone(base + 1, "wr_first");
        driveReq(a, 1'b0);
        waitDone(base + 2, "rd_second");
        driveReq(b, 1'b0);
        tick();

        // Request held one cycle past the done pulse yields exactly one extra.
        a = mk(0, 0, 1, 32'h0000_A000, 32'h0, 32'h0A0A_0A0A, 1);
        base = done_count;
        exp_q.push_back(a);
        applyStimulus(a);
        waitDone(base + 1, "hold_first");
        tick();
        driveReq(a, 1'b0);
        waitDone(base + 2, "hold_extra");
        repeat (6) tick();
        checkOutput("hold_count", done_count, base + 2);
        checkOutput("hold_idle_req", mem_req, 0);

        // Stray ack while idle must not produce anything.
        base = done_count;
        stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        repeat (3) tick();
        checkOutput("stray_ack_req", mem_req, 0);
        checkOutput("stray_ack_done", done_count, base);

        // Reset in the middle of a transaction abandons it silently.
        a = mk(1, 0, 1, 32'h0000_B000, 32'h0, 32'h0, 0);
        base = done_count;
        applyStimulus(a);
        repeat (3) tick();
        checkOutput("abort_busy_req", mem_req, 1);
        rst = 1'b1;
        driveReq(a, 1'b0);
        tick();
        checkOutput("abort_mem_req", mem_req, 0);
        checkOutput("abort_owner", owner, 0);
        checkOutput("abort_rd_data", c_rd_data, 0);
        have_cur = 1'b0;
        rst = 1'b0;
        repeat (5) tick();
        checkOutput("abort_no_done", done_count, base);
        checkOutput("abort_idle_req", mem_req, 0);

`ifdef ARB_TIMEOUT_EN
        a = mk(1, 0, 1, 32'h0000_C000, 32'h0, 32'hDEAD_BEEF, 0);
        base = done_count;
        applyStimulus(a);
        waitDone(base + 1, "timeout_done");
        driveReq(a, 1'b0);
        checkOutput("timeout_busy_len", last_busy_len, 15);
        checkOutput("timeout_flag", arb_timeout, 1);
        b = mk(0, 1, 1, 32'h0000_C100, 32'h0000_0042, 32'h0, 1);
        applyStimulus(b);
        waitDone(base + 2, "post_timeout_done");
        driveReq(b, 1'b0);
        checkOutput("timeout_sticky", arb_timeout, 1);
        pulseReset();
        checkOutput("timeout_cleared", arb_timeout, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
